// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus bundle: instruction ROM port, redirect request and the
// valid/ready instruction stream towards decode.
interface inst_fetch_unit_if;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        id_ready_i;

   modport master (
      output rom_ce, rom_addr, inst_valid_o, inst_o, inst_pc_o,
      input  rom_inst, redirect_valid, redirect_pc, id_ready_i
   );

   modport slave (
      input  rom_ce, rom_addr, inst_valid_o, inst_o, inst_pc_o,
      output rom_inst, redirect_valid, redirect_pc, id_ready_i
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: holds the PC, reads the combinational ROM and buffers
// {pc, inst} pairs in a small FIFO feeding decode. Redirects flush the buffer.
//
// state    | meaning
// st_idle  | just out of reset, no fetch on this edge
// st_run   | fetching whenever there is buffer space and no redirect
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input logic               clk,
   input logic               rst,
   inst_fetch_unit_if.master bus
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic {
      st_idle = 1'b0,
      st_run  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;

   logic [31:0]   mem_pc   [FIFO_DEPTH];
   logic [31:0]   mem_inst [FIFO_DEPTH];

   logic          started;
   logic          not_empty;
   logic          pop;
   logic          push;
   logic          space;

   // started is simply "not in st_idle"
   assign started = (state_q == st_run);

   // handshake qualifiers; redirect masks both push and pop
   always_comb begin
      not_empty = (count_q != '0);
      pop       = not_empty & bus.id_ready_i & ~bus.redirect_valid;
      space     = (count_q < DEPTH_C) | pop;
      push      = started & space & ~bus.redirect_valid;
   end

   // ROM port and head-of-buffer outputs; zeros whenever nothing valid is shown
   always_comb begin
      bus.rom_ce       = push;
      bus.rom_addr     = pc_q;
      bus.inst_valid_o = not_empty & ~bus.redirect_valid;
      bus.inst_o       = '0;
      bus.inst_pc_o    = '0;
      if (bus.inst_valid_o) begin
         bus.inst_o    = mem_inst[rd_ptr_q];
         bus.inst_pc_o = mem_pc[rd_ptr_q];
      end
   end

   // next-state: start-up FSM, PC, buffer pointers and occupancy
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;

      case (state_q)
         st_idle: state_d = st_run;
         st_run:  state_d = st_run;
         default: state_d = st_idle;
      endcase

      if (bus.redirect_valid) begin
         pc_d     = {bus.redirect_pc[31:2], 2'b00};
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // control state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= st_idle;
         pc_q     <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // buffer storage; contents are don't-care while count is zero, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr_q]   <= pc_q;
         mem_inst[wr_ptr_q] <= bus.rom_inst;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_total  = 0;
   int   n_passed = 0;

   inst_fetch_unit_if bus ();

   inst_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ROM model: word i holds i+100
   assign bus.rom_inst = (bus.rom_addr >> 2) + 32'd100;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // advance past the next rising edge; inputs may change afterwards
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic head(input string tag, input logic [31:0] inst, input logic [31:0] pc);
      #1;
      chk({tag, "_valid"}, {31'd0, bus.inst_valid_o}, 32'd1);
      chk({tag, "_inst"}, bus.inst_o, inst);
      chk({tag, "_pc"}, bus.inst_pc_o, pc);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.id_ready_i     = 1'b1;

      // reset values
      #12;
      chk("rst_ce", {31'd0, bus.rom_ce}, 32'd0);
      chk("rst_addr", bus.rom_addr, 32'h0);
      chk("rst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
      chk("rst_inst", bus.inst_o, 32'h0);
      chk("rst_pc", bus.inst_pc_o, 32'h0);

      // 1: release, first edge does not fetch
      rst = 1'b1;
      #1;
      chk("t1_ce_first_edge", {31'd0, bus.rom_ce}, 32'd0);
      step(); #1;
      chk("t1_ce_after_start", {31'd0, bus.rom_ce}, 32'd1);
      chk("t1_addr0", bus.rom_addr, 32'h0);
      chk("t1_empty", {31'd0, bus.inst_valid_o}, 32'd0);
      step(); head("t1_w0", 32'd100, 32'h0);
      step(); head("t1_w1", 32'd101, 32'h4);
      step(); head("t1_w2", 32'd102, 32'h8);

      // 6: async reset mid-stream with buffer non-empty
      bus.id_ready_i = 1'b0;
      rst = 1'b0;
      #1;
      chk("t6_valid", {31'd0, bus.inst_valid_o}, 32'd0);
      chk("t6_inst", bus.inst_o, 32'h0);
      chk("t6_pc", bus.inst_pc_o, 32'h0);
      chk("t6_ce", {31'd0, bus.rom_ce}, 32'd0);
      chk("t6_addr", bus.rom_addr, 32'h0);
      step();

      // 2: decode stalled from reset, buffer fills with two words
      rst = 1'b1;
      step();
      step();
      step(); #1;
      chk("t2_full_ce", {31'd0, bus.rom_ce}, 32'd0);
      chk("t2_full_addr", bus.rom_addr, 32'h8);
      head("t2_full_head", 32'd100, 32'h0);
      step(); #1;
      chk("t2_hold_addr", bus.rom_addr, 32'h8);
      bus.id_ready_i = 1'b1;
      #1;
      chk("t2_ce_on_pop", {31'd0, bus.rom_ce}, 32'd1);
      step(); head("t2_d1", 32'd101, 32'h4);
      step(); head("t2_d2", 32'd102, 32'h8);
      step(); head("t2_d3", 32'd103, 32'hC);

      // 3: redirect to 0x40 with two words buffered
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      #1;
      chk("t3_valid_forced", {31'd0, bus.inst_valid_o}, 32'd0);
      chk("t3_inst_zero", bus.inst_o, 32'h0);
      chk("t3_ce", {31'd0, bus.rom_ce}, 32'd0);
      step();
      bus.redirect_valid = 1'b0;
      #1;
      chk("t3_flushed", {31'd0, bus.inst_valid_o}, 32'd0);
      chk("t3_addr", bus.rom_addr, 32'h40);
      step(); head("t3_new", 32'd116, 32'h40);

      // 4: redirect while decode is ready, misaligned target
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h43;
      #1;
      chk("t4_no_pop", {31'd0, bus.inst_valid_o}, 32'd0);
      step();
      bus.redirect_valid = 1'b0;
      #1;
      chk("t4_addr", bus.rom_addr, 32'h40);
      step(); head("t4_new", 32'd116, 32'h40);

      // 5: redirect to top of address space, PC wraps
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      step();
      bus.redirect_valid = 1'b0;
      #1;
      chk("t5_addr", bus.rom_addr, 32'hFFFF_FFFC);
      step(); head("t5_top", 32'h4000_0063, 32'hFFFF_FFFC);
      chk("t5_wrap_addr", bus.rom_addr, 32'h0);
      step(); head("t5_wrap", 32'd100, 32'h0);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
